mem_arbiter: RTL and testbench

Single-port memory arbiter sharing one external memory bus between instruction fetch (PC/IF stage ROM port) and data access (MEM stage RAM port). Accepts both requests, serializes them onto a multi-cycle ack-based bus with data-before-instruction priority, returns read data to each side, and raises one pipeline stall request until every asserted access in the current cycle has completed. Sits between the PC/MEM stages and the bus bridge; its stall_req feeds the pipeline stall controller that drives stall_pc.

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared bus definitions for the memory arbiter.
//   ADDR_W / DATA_W / SEL_W : external bus address, data and byte-select widths
//   arb_state_e             : arbiter FSM state encoding
package mem_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_INST = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serializes instruction fetches and data accesses
// onto one ack-based external bus, data side first, and holds the pipeline
// (stall_req) until every access requested in the current cycle has completed.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   if_en, if_addr, if_rdata         fetch request / address / returned instruction
//   mem_en, mem_write_en, mem_addr,
//   mem_wdata, mem_rdata             data request / strobes / address / store / load data
//   stall_req                        combinational pipeline hold request
//   bus_req, bus_we, bus_addr,
//   bus_wdata                        registered bus request outputs
//   bus_rdata, bus_ack               bus read data and one-cycle completion strobe
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              if_en,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_en,
  input  logic [SEL_W-1:0]  mem_write_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stall_req,
  output logic              bus_req,
  output logic [SEL_W-1:0]  bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  arb_state_e        state_reg, state_next;
  logic              bus_req_reg, bus_req_next;
  logic [SEL_W-1:0]  bus_we_reg, bus_we_next;
  logic [ADDR_W-1:0] bus_addr_reg, bus_addr_next;
  logic [DATA_W-1:0] bus_wdata_reg, bus_wdata_next;
  logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0] mem_rdata_reg, mem_rdata_next;
  logic              mem_done_reg, mem_done_next;
  logic              if_done_reg, if_done_next;
  logic              mem_pend;
  logic              if_pend;

  // An access is pending while it is requested and has not yet been served
  // within the current stall window.
  assign mem_pend  = mem_en & ~mem_done_reg;
  assign if_pend   = if_en & ~if_done_reg;
  assign stall_req = mem_pend | if_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= '0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      mem_rdata_reg <= '0;
      mem_done_reg  <= 1'b0;
      if_done_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bus_req_reg   <= bus_req_next;
      bus_we_reg    <= bus_we_next;
      bus_addr_reg  <= bus_addr_next;
      bus_wdata_reg <= bus_wdata_next;
      if_rdata_reg  <= if_rdata_next;
      mem_rdata_reg <= mem_rdata_next;
      mem_done_reg  <= mem_done_next;
      if_done_reg   <= if_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bus_req_next   = bus_req_reg;
    bus_we_next    = bus_we_reg;
    bus_addr_next  = bus_addr_reg;
    bus_wdata_next = bus_wdata_reg;
    if_rdata_next  = if_rdata_reg;
    mem_rdata_next = mem_rdata_reg;
    mem_done_next  = mem_done_reg;
    if_done_next   = if_done_reg;

    case (state_reg)
      ST_IDLE: begin
        // bus_ack is deliberately not looked at here: a stale ack (e.g. one
        // that belonged to an access killed by reset) must not mark anything done.
        if (mem_pend) begin
          bus_req_next   = 1'b1;
          bus_addr_next  = mem_addr;
          bus_we_next    = mem_write_en;
          bus_wdata_next = mem_wdata;
          state_next     = ST_DATA;
        end else if (if_pend) begin
          bus_req_next   = 1'b1;
          bus_addr_next  = if_addr;
          bus_we_next    = '0;
          bus_wdata_next = '0;
          state_next     = ST_INST;
        end else begin
          bus_req_next   = 1'b0;
        end
      end
      ST_DATA: begin
        // Writes also capture bus_rdata; the load port simply reflects the
        // last completed data access.
        if (bus_ack) begin
          bus_req_next   = 1'b0;
          mem_done_next  = 1'b1;
          mem_rdata_next = bus_rdata;
          state_next     = ST_IDLE;
        end
      end
      ST_INST: begin
        if (bus_ack) begin
          bus_req_next  = 1'b0;
          if_done_next  = 1'b1;
          if_rdata_next = bus_rdata;
          state_next    = ST_IDLE;
        end
      end
      default: begin
        bus_req_next = 1'b0;
        state_next   = ST_IDLE;
      end
    endcase

    // Once nothing is outstanding the stall window is over; the flags reset
    // so the next request (even to the same address) is issued afresh. This
    // overrides a set from an ack whose requester has already gone away.
    if (!stall_req) begin
      mem_done_next = 1'b0;
      if_done_next  = 1'b0;
    end
  end

  assign bus_req   = bus_req_reg;
  assign bus_we    = bus_we_reg;
  assign bus_addr  = bus_addr_reg;
  assign bus_wdata = bus_wdata_reg;
  assign if_rdata  = if_rdata_reg;
  assign mem_rdata = mem_rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_en;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        mem_en;
  logic [3:0]  mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_req;
  logic        bus_req;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .if_en        (if_en),
    .if_addr      (if_addr),
    .if_rdata     (if_rdata),
    .mem_en       (mem_en),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .stall_req    (stall_req),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs set afterwards apply
  // to the cycle that edge starts.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_en = 1'b1; if_addr = 32'hbfc00000;
    tick(); tick();
    #1;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req got %b exp 0", bus_req); end
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL reset_stall got %b exp 1", stall_req); end
    checks++; if (if_rdata !== 32'h0) begin errors++; $display("FAIL reset_if_rdata got %h exp 00000000", if_rdata); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_mem_rdata got %h exp 00000000", mem_rdata); end
    checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL reset_bus_addr got %h exp 00000000", bus_addr); end
    rst = 1'b0;
    tick();
    #1;
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL post_reset_issue got %b exp 1", bus_req); end
    checks++; if (bus_addr !== 32'hbfc00000) begin errors++; $display("FAIL post_reset_addr got %h exp bfc00000", bus_addr); end
    bus_ack = 1'b1; bus_rdata = 32'h00000000;
    tick();
    bus_ack = 1'b0;
    #1;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL post_reset_stall got %b exp 0", stall_req); end
    if_en = 1'b0;
    $display("txn reset: fetch after release addr=bfc00000");
    tick();
  endtask

  task automatic test_lone_fetch();
    int stalls = 0;
    if_en = 1'b1; if_addr = 32'hbfc00000;
    for (int c = 0; c < 8; c++) begin
      bus_ack   = (c == 3);
      bus_rdata = (c == 3) ? 32'h3c080001 : 32'hdeadbeef;
      #1;
      if (stall_req) stalls++;
      if (c == 0) begin
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL fetch_c0_bus_req got %b exp 0", bus_req); end
      end
      if (c >= 1 && c <= 3) begin
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL fetch_bus_req c%0d got %b exp 1", c, bus_req); end
        checks++; if (bus_addr !== 32'hbfc00000) begin errors++; $display("FAIL fetch_bus_addr c%0d got %h exp bfc00000", c, bus_addr); end
        checks++; if (bus_we !== 4'b0000) begin errors++; $display("FAIL fetch_bus_we c%0d got %b exp 0000", c, bus_we); end
      end
      if (c == 4) begin
        checks++; if (if_rdata !== 32'h3c080001) begin errors++; $display("FAIL fetch_if_rdata got %h exp 3c080001", if_rdata); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL fetch_bus_req_after got %b exp 0", bus_req); end
        if_en = 1'b0;
      end
      tick();
    end
    bus_ack = 1'b0;
    checks++; if (stalls !== 4) begin errors++; $display("FAIL fetch_stall_cycles got %0d exp 4", stalls); end
    $display("txn lone fetch addr=bfc00000 rdata=%h stalls=%0d", if_rdata, stalls);
  endtask

  task automatic test_simultaneous();
    int stalls = 0;
    mem_en = 1'b1; mem_write_en = 4'b0000; mem_addr = 32'h80000010; mem_wdata = 32'h0;
    if_en = 1'b1; if_addr = 32'hbfc00004;
    for (int c = 0; c < 7; c++) begin
      bus_ack   = (c == 1) || (c == 3);
      bus_rdata = (c == 1) ? 32'haaaa0001 : ((c == 3) ? 32'hbbbb0002 : 32'h0);
      #1;
      if (stall_req) stalls++;
      if (c == 1) begin
        checks++; if (bus_addr !== 32'h80000010) begin errors++; $display("FAIL simul_data_first got %h exp 80000010", bus_addr); end
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL simul_data_req got %b exp 1", bus_req); end
      end
      if (c == 2) begin
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL simul_idle_gap got %b exp 0", bus_req); end
      end
      if (c == 3) begin
        checks++; if (bus_addr !== 32'hbfc00004) begin errors++; $display("FAIL simul_fetch_addr got %h exp bfc00004", bus_addr); end
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL simul_fetch_req got %b exp 1", bus_req); end
      end
      if (c == 4) begin
        checks++; if (mem_rdata !== 32'haaaa0001) begin errors++; $display("FAIL simul_mem_rdata got %h exp aaaa0001", mem_rdata); end
        checks++; if (if_rdata !== 32'hbbbb0002) begin errors++; $display("FAIL simul_if_rdata got %h exp bbbb0002", if_rdata); end
        mem_en = 1'b0; if_en = 1'b0;
      end
      tick();
    end
    bus_ack = 1'b0;
    checks++; if (stalls !== 4) begin errors++; $display("FAIL simul_stall_cycles got %0d exp 4", stalls); end
    $display("txn load+fetch mem=%h if=%h stalls=%0d", mem_rdata, if_rdata, stalls);
  endtask

  task automatic test_store();
    int req_cycles = 0;
    mem_en = 1'b1; mem_write_en = 4'b0011; mem_addr = 32'h80000020; mem_wdata = 32'h12345678;
    for (int c = 0; c < 7; c++) begin
      bus_ack   = (c == 2);
      bus_rdata = (c == 2) ? 32'hcafef00d : 32'h0;
      #1;
      if (bus_req) req_cycles++;
      if (c == 1 || c == 2) begin
        checks++; if (bus_we !== 4'b0011) begin errors++; $display("FAIL store_bus_we c%0d got %b exp 0011", c, bus_we); end
        checks++; if (bus_wdata !== 32'h12345678) begin errors++; $display("FAIL store_bus_wdata c%0d got %h exp 12345678", c, bus_wdata); end
        checks++; if (bus_addr !== 32'h80000020) begin errors++; $display("FAIL store_bus_addr c%0d got %h exp 80000020", c, bus_addr); end
      end
      if (c == 3) begin
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL store_stall_done got %b exp 0", stall_req); end
        checks++; if (mem_rdata !== 32'hcafef00d) begin errors++; $display("FAIL store_mem_rdata got %h exp cafef00d", mem_rdata); end
        mem_en = 1'b0;
      end
      tick();
    end
    bus_ack = 1'b0;
    checks++; if (req_cycles !== 2) begin errors++; $display("FAIL store_req_cycles got %0d exp 2", req_cycles); end
    $display("txn store addr=80000020 we=0011 wdata=12345678 req_cycles=%0d", req_cycles);
  endtask

  task automatic test_reset_mid_access();
    mem_en = 1'b1; mem_write_en = 4'b0000; mem_addr = 32'h80000030;
    tick();  // IDLE issues the load
    #1;
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rstmid_issue got %b exp 1", bus_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h0badbad0;
    #1;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rstmid_bus_req got %b exp 0", bus_req); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_mem_rdata got %h exp 00000000", mem_rdata); end
    tick();
    bus_ack = 1'b0;
    #1;
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_stale_ack got %h exp 00000000", mem_rdata); end
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL rstmid_stall got %b exp 1", stall_req); end
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rstmid_reissue got %b exp 1", bus_req); end
    bus_ack = 1'b1; bus_rdata = 32'h55aa55aa;
    tick();
    bus_ack = 1'b0;
    #1;
    checks++; if (mem_rdata !== 32'h55aa55aa) begin errors++; $display("FAIL rstmid_final_rdata got %h exp 55aa55aa", mem_rdata); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rstmid_final_stall got %b exp 0", stall_req); end
    mem_en = 1'b0;
    $display("txn reset mid load addr=80000030 rdata=%h", mem_rdata);
    tick();
  endtask

  task automatic test_back_to_back();
    int req_cycles = 0;
    if_en = 1'b1; if_addr = 32'hbfc00100;
    for (int c = 0; c < 8; c++) begin
      bus_ack   = (c == 1) || (c == 4);
      bus_rdata = (c == 1) ? 32'h11111111 : ((c == 4) ? 32'h22222222 : 32'h0);
      #1;
      if (bus_req) req_cycles++;
      if (c == 2) begin
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL b2b_gap_stall got %b exp 0", stall_req); end
        checks++; if (if_rdata !== 32'h11111111) begin errors++; $display("FAIL b2b_first_rdata got %h exp 11111111", if_rdata); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL b2b_no_reissue got %b exp 0", bus_req); end
        if_addr = 32'hbfc00104;
      end
      if (c == 3) begin
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL b2b_second_stall got %b exp 1", stall_req); end
      end
      if (c == 4) begin
        checks++; if (bus_addr !== 32'hbfc00104) begin errors++; $display("FAIL b2b_second_addr got %h exp bfc00104", bus_addr); end
      end
      if (c == 5) begin
        checks++; if (if_rdata !== 32'h22222222) begin errors++; $display("FAIL b2b_second_rdata got %h exp 22222222", if_rdata); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL b2b_second_done got %b exp 0", stall_req); end
        if_en = 1'b0;
      end
      tick();
    end
    bus_ack = 1'b0;
    checks++; if (req_cycles !== 2) begin errors++; $display("FAIL b2b_req_cycles got %0d exp 2", req_cycles); end
    $display("txn back-to-back fetches bfc00100/bfc00104 req_cycles=%0d", req_cycles);
  endtask

  initial begin
    rst = 1'b1; if_en = 1'b0; if_addr = '0;
    mem_en = 1'b0; mem_write_en = '0; mem_addr = '0; mem_wdata = '0;
    bus_rdata = '0; bus_ack = 1'b0;
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_store();
    test_reset_mid_access();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
